// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the RV32 multi-cycle control sequencer: state codes and parameter defaults.
package cpu_ctrl_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int TMO_W_DEF   = 8;
    localparam int TMO_MAX_DEF = 255;

    // HALT has no code of its own: it is S_RESET with the sticky halt flag set.
    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_I   = 3'd2,
        S_DECODE   = 3'd3,
        S_EXEC     = 3'd4,
        S_MEM_REQ  = 3'd5,
        S_MEM_WAIT = 3'd6,
        S_WB       = 3'd7
    } state_t;

endpackage

// File: rtl/cpu_seq_timer.sv
// Memory-wait watchdog for cpu_seq_ctrl; only present when CPU_SEQ_CTRL_TIMEOUT_EN is defined.
`ifdef CPU_SEQ_CTRL_TIMEOUT_EN
module cpu_seq_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_MAX = TMO_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    // Fires during the TMO_MAX-th counted cycle so the sequencer leaves at that edge.
    assign o_expired = i_en && (r_cnt == TMO_W'(TMO_MAX - 1));

endmodule
`endif

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle RV32 control sequencer: fetch handshake, decode, execute, optional LSU access, writeback.
// Optional memory-wait watchdog enabled by defining CPU_SEQ_CTRL_TIMEOUT_EN.
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_MAX = TMO_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_resp_valid,
    output logic             inst_en,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_is_ebreak,
    input  logic             dec_rf_wen,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_resp_valid,
    output logic             pc_wen,
    output logic             rf_wen,
    output logic             halt,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state, w_state_n;
    logic             r_halt, w_halt_n;
    logic             r_err, w_err_n;
    logic [CNT_W-1:0] r_retired;
    logic             w_tmo_exp;
    logic             w_mem_op;

    assign w_mem_op = dec_is_load | dec_is_store;

`ifdef CPU_SEQ_CTRL_TIMEOUT_EN
    logic w_tmo_en;

    assign w_tmo_en = !r_halt &&
                      (r_state inside {S_FETCH, S_WAIT_I, S_MEM_REQ, S_MEM_WAIT});

    // Both waiting phases are entered from a non-waiting state, so clearing whenever
    // idle is the same as clearing on entry to FETCH/MEM_REQ.
    cpu_seq_timer #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_tmo_en),
        .i_en      (w_tmo_en),
        .o_expired (w_tmo_exp)
    );
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TMO_W > TMO_MAX);
    assign w_tmo_exp    = 1'b0;
`endif

    always_comb begin
        w_state_n     = r_state;
        w_halt_n      = r_halt;
        w_err_n       = r_err;
        ifu_req_valid = 1'b0;
        inst_en       = 1'b0;
        lsu_req_valid = 1'b0;
        pc_wen        = 1'b0;
        rf_wen        = 1'b0;
        if (!r_halt) begin
            case (r_state)
                S_RESET: w_state_n = S_FETCH;
                S_FETCH: begin
                    ifu_req_valid = 1'b1;
                    if (ifu_req_ready) begin
                        if (ifu_resp_valid) begin
                            inst_en   = 1'b1;
                            w_state_n = S_DECODE;
                        end else begin
                            w_state_n = S_WAIT_I;
                        end
                    end
                end
                S_WAIT_I: begin
                    if (ifu_resp_valid) begin
                        inst_en   = 1'b1;
                        w_state_n = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_is_ebreak) begin
                        w_state_n = S_RESET;
                        w_halt_n  = 1'b1;
                    end else begin
                        w_state_n = S_EXEC;
                    end
                end
                S_EXEC: w_state_n = w_mem_op ? S_MEM_REQ : S_WB;
                S_MEM_REQ: begin
                    lsu_req_valid = 1'b1;
                    if (lsu_req_ready) begin
                        w_state_n = lsu_resp_valid ? S_WB : S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (lsu_resp_valid) begin
                        w_state_n = S_WB;
                    end
                end
                S_WB: begin
                    pc_wen    = 1'b1;
                    // load+store together behaves as a load, so it still writes back
                    rf_wen    = dec_rf_wen & ~(dec_is_store & ~dec_is_load);
                    w_state_n = S_FETCH;
                end
                default: w_state_n = S_RESET;
            endcase
            if (w_tmo_exp) begin
                inst_en   = 1'b0;
                w_state_n = S_RESET;
                w_halt_n  = 1'b1;
                w_err_n   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_RESET;
            r_halt    <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_n;
            r_halt  <= w_halt_n;
            r_err   <= w_err_n;
            if (pc_wen) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign state   = r_state;
    assign halt    = r_halt;
    assign err     = r_err;
    assign retired = r_retired;

endmodule
